// File: rtl/ram_arb_pkg.sv
// Shared widths, burst stride and FSM encoding for the SDRAM port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W       = 25;
    localparam int DATA_W       = 128;
    localparam int BURST_STRIDE = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/ram_arb_tag_fifo.sv
// Tag FIFO remembering which read requester owns each outstanding read.
module ram_arb_tag_fifo
    import ram_arb_pkg::*;
#(
    parameter  int TAG_W = 2,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] pop_tag_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_tag_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push into a full FIFO is fine then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_tag_i;
    end

endmodule

// File: rtl/ram_arbiter.sv
// SDRAM port arbiter: camera writes first, round-robin reads, tagged returns.
// Optional read starvation guard: define RAM_ARB_STARVE_GUARD_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_RD          = 3,
    parameter int TAG_DEPTH     = 8,
    parameter int MAX_WR_STREAK = 4
) (
    input  logic                   clk_133M,
    input  logic                   rst_133M,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_address,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ack,
    input  logic [N_RD-1:0]        rd_req,
    input  logic [ADDR_W*N_RD-1:0] rd_address,
    output logic [N_RD-1:0]        rd_ack,
    output logic [N_RD-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   ram_busy,
    input  logic                   ram_ack,
    input  logic                   ram_rd_valid,
    input  logic [DATA_W-1:0]      ram_rd_data,
    output logic                   ram_req,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_address,
    output logic [DATA_W-1:0]      ram_wr_data,
    output logic                   tag_err
);

    localparam int PTR_W = (N_RD > 1) ? $clog2(N_RD) : 1;

    if (N_RD < 1 || N_RD > 8 || TAG_DEPTH < 2 ||
        (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || MAX_WR_STREAK < 1) begin : g_bad_cfg
        $error("ram_arbiter: unsupported parameter set");
    end

    state_t            state_q;
    logic [PTR_W-1:0]  winner_q;
    logic [PTR_W-1:0]  rr_q;
    logic              ram_req_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic [DATA_W-1:0] ram_wr_data_q;
    logic [N_RD-1:0]   rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              tag_err_q;

    logic [PTR_W-1:0]  rd_win;
    logic [PTR_W-1:0]  rr_nxt;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic              rd_found;
    logic              rd_ok;
    logic              grant_wr;
    logic              grant_rd;
    logic              arb_go;
    logic              txn_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W-1:0]  pop_tag;
    int                idx;

    always_comb begin
        rd_found = 1'b0;
        rd_win   = '0;
        idx      = 0;
        for (int k = 0; k < N_RD; k++) begin
            idx = (int'(rr_q) + k) % N_RD;
            if (!rd_found && rd_req[idx[PTR_W-1:0]]) begin
                rd_found = 1'b1;
                rd_win   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        rd_addr_sel = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (rd_win == PTR_W'(i))
                rd_addr_sel = rd_address[ADDR_W*i +: ADDR_W];
        end
    end

    assign rd_ok = rd_found & ~fifo_full;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                force_rd;

    assign force_rd = (streak_q == STREAK_W'(MAX_WR_STREAK)) & rd_ok;
    assign grant_wr = wr_req & ~force_rd;

    always_comb begin
        streak_d = streak_q;
        if (~|rd_req)
            streak_d = '0;
        else if (arb_go && grant_rd)
            streak_d = '0;
        else if (arb_go && grant_wr && streak_q != STREAK_W'(MAX_WR_STREAK))
            streak_d = streak_q + STREAK_W'(1);
    end

    always_ff @(posedge clk_133M) begin
        if (rst_133M)
            streak_q <= '0;
        else
            streak_q <= streak_d;
    end
`else
    assign grant_wr = wr_req;
`endif

    assign grant_rd = ~grant_wr & rd_ok;
    assign arb_go   = (state_q == IDLE) & ~ram_busy & (grant_wr | grant_rd);
    assign txn_done = (state_q == ISSUE) & ram_ack;
    assign rr_nxt   = (winner_q == PTR_W'(N_RD - 1)) ? '0 : winner_q + 1'b1;

    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            state_q       <= IDLE;
            ram_req_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_wr_data_q <= '0;
            winner_q      <= '0;
            rr_q          <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_go) begin
                        state_q       <= ISSUE;
                        ram_req_q     <= 1'b1;
                        ram_we_q      <= grant_wr;
                        ram_address_q <= grant_wr ? wr_address : rd_addr_sel;
                        winner_q      <= rd_win;
                        if (grant_wr)
                            ram_wr_data_q <= wr_data;
                    end
                end
                ISSUE: begin
                    if (ram_ack) begin
                        state_q   <= IDLE;
                        ram_req_q <= 1'b0;
                        if (!ram_we_q)
                            rr_q <= rr_nxt;
                    end
                end
            endcase
        end
    end

    // Read data comes back in issue order, so the oldest tag names its owner.
    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            if (ram_rd_valid) begin
                if (fifo_empty) begin
                    tag_err_q <= 1'b1;
                end else begin
                    rd_valid_q <= N_RD'(1) << pop_tag;
                    rd_data_q  <= ram_rd_data;
                end
            end
        end
    end

    ram_arb_tag_fifo #(
        .TAG_W (PTR_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i      (clk_133M),
        .rst_i      (rst_133M),
        .push_i     (txn_done & ~ram_we_q),
        .push_tag_i (winner_q),
        .pop_i      (ram_rd_valid),
        .pop_tag_o  (pop_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    ()
    );

    assign wr_ack      = txn_done & ram_we_q;
    assign rd_ack      = (txn_done & ~ram_we_q) ? (N_RD'(1) << winner_q) : '0;
    assign ram_req     = ram_req_q;
    assign ram_we      = ram_we_q;
    assign ram_address = ram_address_q;
    assign ram_wr_data = ram_wr_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign tag_err     = tag_err_q;

endmodule
